id_ex_stage: RTL and testbench

//  ID/EX pipeline register with operand forwarding and load-use hazard detection.

---
 rtl/id_ex_stage.sv | 189 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use detection
//
// Purpose:
//   Latches the decoded instruction from ID and presents forwarded ALU operands,
//   the registered ALU op and the MEM/WB control bits to EX. Detects a load-use
//   dependency against the instruction in EX and raises hazard_stall so that ID
//   and the PC hold for one cycle while a bubble is inserted.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   stall                      downstream hold, register keeps its contents
//   flush                      squash, next EX state is a bubble
//   id_*                       decoded instruction fields from ID
//   mem_reg_write/rd/result    EX/MEM write-back source for forwarding
//   wb_reg_write/rd/result     MEM/WB write-back source for forwarding/bypass
//   alu_a, alu_b, alu_control  ALU operands and op for EX
//   ex_store_data              forwarded rt value for stores
//   ex_dest, ex_valid, ex_*    registered destination and control bits
//   hazard_stall               load-use detected, ID/PC must hold this cycle
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [2:0]        id_alu_control,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              id_branch,
  input  logic              mem_reg_write,
  input  logic [RA_W-1:0]   mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_reg_write,
  input  logic [RA_W-1:0]   wb_rd,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_control,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [RA_W-1:0]   ex_dest,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_branch,
  output logic              hazard_stall
);

  logic              valid_q, valid_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              mem_to_reg_q, mem_to_reg_d;
  logic              branch_q, branch_d;
  logic [2:0]        alu_control_q, alu_control_d;
  logic              alu_src_q, alu_src_d;
  logic [RA_W-1:0]   rs_q, rs_d;
  logic [RA_W-1:0]   rt_q, rt_d;
  logic [RA_W-1:0]   dest_q, dest_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q, imm_d;

  // A write-back source only counts when it writes a non-zero register.
  logic mem_wr_live, wb_wr_live;
  assign mem_wr_live = mem_reg_write && (mem_rd != '0);
  assign wb_wr_live  = wb_reg_write  && (wb_rd  != '0);

  assign hazard_stall = valid_q && mem_read_q && (dest_q != '0) && id_valid &&
                        ((dest_q == id_rs) || (dest_q == id_rt));

  always_comb begin
    valid_d       = valid_q;
    reg_write_d   = reg_write_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_to_reg_d  = mem_to_reg_q;
    branch_d      = branch_q;
    alu_control_d = alu_control_q;
    alu_src_d     = alu_src_q;
    rs_d          = rs_q;
    rt_d          = rt_q;
    dest_d        = dest_q;
    rs_data_d     = rs_data_q;
    rt_data_d     = rt_data_q;
    imm_d         = imm_q;

    if (flush || (!stall && hazard_stall)) begin
      // Bubble: data fields keep stale values, only control is cleared.
      valid_d       = 1'b0;
      reg_write_d   = 1'b0;
      mem_read_d    = 1'b0;
      mem_write_d   = 1'b0;
      mem_to_reg_d  = 1'b0;
      branch_d      = 1'b0;
      alu_control_d = 3'b000;
    end else if (stall) begin
      // A write-back landing while held must not be lost once EX resumes.
      if (wb_wr_live && (wb_rd == rs_q)) rs_data_d = wb_result;
      if (wb_wr_live && (wb_rd == rt_q)) rt_data_d = wb_result;
    end else begin
      valid_d       = id_valid;
      reg_write_d   = id_valid && id_reg_write;
      mem_read_d    = id_valid && id_mem_read;
      mem_write_d   = id_valid && id_mem_write;
      mem_to_reg_d  = id_valid && id_mem_to_reg;
      branch_d      = id_valid && id_branch;
      alu_control_d = id_valid ? id_alu_control : 3'b000;
      alu_src_d     = id_alu_src;
      rs_d          = id_rs;
      rt_d          = id_rt;
      dest_d        = id_reg_dst ? id_rd : id_rt;
      imm_d         = id_imm;
      // The register file is read before WB writes it, so bypass on capture.
      rs_data_d     = (wb_wr_live && (wb_rd == id_rs)) ? wb_result : id_rs_data;
      rt_data_d     = (wb_wr_live && (wb_rd == id_rt)) ? wb_result : id_rt_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q       <= 1'b0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      branch_q      <= 1'b0;
      alu_control_q <= 3'b000;
      alu_src_q     <= 1'b0;
      rs_q          <= '0;
      rt_q          <= '0;
      dest_q        <= '0;
      rs_data_q     <= '0;
      rt_data_q     <= '0;
      imm_q         <= '0;
    end else begin
      valid_q       <= valid_d;
      reg_write_q   <= reg_write_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_to_reg_q  <= mem_to_reg_d;
      branch_q      <= branch_d;
      alu_control_q <= alu_control_d;
      alu_src_q     <= alu_src_d;
      rs_q          <= rs_d;
      rt_q          <= rt_d;
      dest_q        <= dest_d;
      rs_data_q     <= rs_data_d;
      rt_data_q     <= rt_data_d;
      imm_q         <= imm_d;
    end
  end

  // Forwarding: MEM is the younger result, so it wins over WB.
  always_comb begin
    alu_a = rs_data_q;
    if (mem_wr_live && (mem_rd == rs_q))     alu_a = mem_result;
    else if (wb_wr_live && (wb_rd == rs_q))  alu_a = wb_result;

    ex_store_data = rt_data_q;
    if (mem_wr_live && (mem_rd == rt_q))     ex_store_data = mem_result;
    else if (wb_wr_live && (wb_rd == rt_q))  ex_store_data = wb_result;
  end

  assign alu_b         = alu_src_q ? imm_q : ex_store_data;
  assign alu_control   = alu_control_q;
  assign ex_dest       = dest_q;
  assign ex_valid      = valid_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_mem_to_reg = mem_to_reg_q;
  assign ex_branch     = branch_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [2:0]  id_alu_control;
  logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write;
  logic        id_mem_to_reg, id_branch;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [2:0]  alu_control;
  logic [4:0]  ex_dest;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic        ex_branch, hazard_stall;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .RA_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_control(id_alu_control),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_branch(ex_branch), .hazard_stall(hazard_stall)
  );

  // ctl = {reg_write, mem_read, mem_write, mem_to_reg, branch}
  // cwb_* : WB port during the capture edge; m_*/w_* : MEM/WB ports while checking.
  typedef struct packed {
    logic        v;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_d, rt_d, imm;
    logic [2:0]  op;
    logic        src, dst;
    logic [4:0]  ctl;
    logic        cwb_we;
    logic [4:0]  cwb_rd;
    logic [31:0] cwb_res;
    logic        m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_res;
    logic        w_we;
    logic [4:0]  w_rd;
    logic [31:0] w_res;
    logic [31:0] e_a, e_b, e_st;
    logic [4:0]  e_dest;
  } vec_t;

  vec_t vt[11];
  vec_t sb[$];
  vec_t e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive_id(input vec_t x);
    id_valid       = x.v;
    id_rs          = x.rs;
    id_rt          = x.rt;
    id_rd          = x.rd;
    id_rs_data     = x.rs_d;
    id_rt_data     = x.rt_d;
    id_imm         = x.imm;
    id_alu_control = x.op;
    id_alu_src     = x.src;
    id_reg_dst     = x.dst;
    {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch} = x.ctl;
    wb_reg_write   = x.cwb_we;
    wb_rd          = x.cwb_rd;
    wb_result      = x.cwb_res;
    mem_reg_write  = 1'b0;
    mem_rd         = '0;
    mem_result     = '0;
  endtask

  task automatic set_fwd(input vec_t x);
    mem_reg_write = x.m_we;
    mem_rd        = x.m_rd;
    mem_result    = x.m_res;
    wb_reg_write  = x.w_we;
    wb_rd         = x.w_rd;
    wb_result     = x.w_res;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] ex_ctl();
    return {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch};
  endfunction

  initial begin
    vec_t lw, add, junk;

    vt[0]  = '{v:1, rs:1, rt:2, rd:3, rs_d:'h100, rt_d:'h200, imm:'h7, op:3'b010, dst:1,
               ctl:5'b10000, e_a:'h100, e_b:'h200, e_st:'h200, e_dest:3, default:'0};
    vt[1]  = '{v:1, rs:4, rt:6, rd:7, rs_d:'hAA, rt_d:'hBB, imm:'hFFFF_FFF0, op:3'b110, src:1,
               ctl:5'b00100, e_a:'hAA, e_b:'hFFFF_FFF0, e_st:'hBB, e_dest:6, default:'0};
    vt[2]  = '{v:1, rs:10, rt:11, rd:12, rs_d:'h1, rt_d:'h2, op:3'b000, dst:1, ctl:5'b10010,
               cwb_we:1, cwb_rd:10, cwb_res:'h5555, e_a:'h5555, e_b:'h2, e_st:'h2, e_dest:12,
               default:'0};
    vt[3]  = '{v:1, rs:10, rt:11, rd:13, rs_d:'h1, rt_d:'h2, op:3'b001, dst:1, ctl:5'b00001,
               cwb_we:1, cwb_rd:11, cwb_res:'h6666, e_a:'h1, e_b:'h6666, e_st:'h6666, e_dest:13,
               default:'0};
    vt[4]  = '{v:1, rs:0, rt:0, rd:0, rs_d:'h33, rt_d:'h44, op:3'b111, dst:1, ctl:5'b10000,
               cwb_we:1, cwb_rd:0, cwb_res:'hDEAD, m_we:1, m_rd:0, m_res:'hFF, w_we:1, w_rd:0,
               w_res:'hEE, e_a:'h33, e_b:'h44, e_st:'h44, e_dest:0, default:'0};
    vt[5]  = '{v:1, rs:5, rt:6, rd:2, rs_d:'h1, rt_d:'h2, op:3'b010, dst:1, ctl:5'b10000,
               m_we:1, m_rd:5, m_res:'h11, w_we:1, w_rd:5, w_res:'h22,
               e_a:'h11, e_b:'h2, e_st:'h2, e_dest:2, default:'0};
    vt[6]  = '{v:1, rs:5, rt:6, rd:2, rs_d:'h1, rt_d:'h2, op:3'b010, dst:1, ctl:5'b10000,
               m_we:0, m_rd:5, m_res:'h11, w_we:1, w_rd:5, w_res:'h22,
               e_a:'h22, e_b:'h2, e_st:'h2, e_dest:2, default:'0};
    vt[7]  = '{v:1, rs:5, rt:6, rd:2, rs_d:'h1, rt_d:'h2, imm:'h40, op:3'b010, src:1,
               ctl:5'b00100, m_we:1, m_rd:6, m_res:'h66, w_we:1, w_rd:6, w_res:'h77,
               e_a:'h1, e_b:'h40, e_st:'h66, e_dest:6, default:'0};
    vt[8]  = '{v:1, rs:5, rt:6, rd:2, rs_d:'h1, rt_d:'h2, op:3'b110, dst:1, ctl:5'b10000,
               m_we:1, m_rd:7, m_res:'h99, w_we:1, w_rd:6, w_res:'h77,
               e_a:'h1, e_b:'h77, e_st:'h77, e_dest:2, default:'0};
    vt[9]  = '{v:0, rs:1, rt:2, rd:3, rs_d:'h10, rt_d:'h20, op:3'b010, dst:1, ctl:5'b11111,
               e_a:'h10, e_b:'h20, e_st:'h20, e_dest:3, default:'0};
    vt[10] = '{v:1, rs:31, rt:30, rd:29, rs_d:'hFFFF_FFFF, rt_d:'h0, imm:'h1, op:3'b110,
               ctl:5'b10100, cwb_we:1, cwb_rd:30, cwb_res:'h1234, w_we:1, w_rd:31,
               w_res:'h4321, e_a:'h4321, e_b:'h1234, e_st:'h1234, e_dest:30, default:'0};

    // Reset with junk on every input.
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    junk = '{v:1, rs:5'd7, rt:5'd9, rd:5'd4, rs_d:$urandom, rt_d:$urandom, imm:$urandom,
             op:3'b111, src:0, dst:1, ctl:5'b11111, cwb_we:1, cwb_rd:5'd7, cwb_res:$urandom,
             default:'0};
    drive_id(junk);
    mem_reg_write = 1'b1; mem_rd = 5'd3; mem_result = $urandom;
    tick();
    tick();
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_ctl", {27'd0, ex_ctl()}, 32'd0);
    chk("rst_aluctl", {29'd0, alu_control}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_hazard", {31'd0, hazard_stall}, 32'd0);
    rst_n = 1'b1;

    // Table of single-instruction loads: expectations queued at drive, popped at check.
    for (int i = 0; i < 11; i++) begin
      drive_id(vt[i]);
      sb.push_back(vt[i]);
      tick();
      set_fwd(vt[i]);
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d_alu_a", i), alu_a, e.e_a);
      chk($sformatf("v%0d_alu_b", i), alu_b, e.e_b);
      chk($sformatf("v%0d_store", i), ex_store_data, e.e_st);
      chk($sformatf("v%0d_dest", i), {27'd0, ex_dest}, {27'd0, e.e_dest});
      chk($sformatf("v%0d_valid", i), {31'd0, ex_valid}, {31'd0, e.v});
      chk($sformatf("v%0d_ctl", i), {27'd0, ex_ctl()}, {27'd0, e.v ? e.ctl : 5'b0});
      chk($sformatf("v%0d_aluctl", i), {29'd0, alu_control}, {29'd0, e.v ? e.op : 3'b0});
      chk($sformatf("v%0d_hazard", i), {31'd0, hazard_stall}, 32'd0);
    end

    // Load-use: lw $8 then add using $8.
    lw  = '{v:1, rs:1, rt:8, rd:0, rs_d:'h1000, imm:'h4, op:3'b010, src:1, ctl:5'b11010,
            default:'0};
    add = '{v:1, rs:8, rt:3, rd:9, rs_d:'h0, rt_d:'h3, op:3'b010, dst:1, ctl:5'b10000,
            default:'0};
    drive_id(lw);
    tick();
    drive_id(add);
    #1;
    chk("lu_hazard_on", {31'd0, hazard_stall}, 32'd1);
    tick();
    chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_bubble_ctl", {27'd0, ex_ctl()}, 32'd0);
    chk("lu_hazard_off", {31'd0, hazard_stall}, 32'd0);
    mem_reg_write = 1'b1; mem_rd = 5'd8; mem_result = 32'h0;
    tick();
    mem_reg_write = 1'b0; mem_rd = '0;
    wb_reg_write = 1'b1; wb_rd = 5'd8; wb_result = 32'h8888;
    #1;
    chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_add_dest", {27'd0, ex_dest}, 32'd9);
    chk("lu_add_fwd_wb", alu_a, 32'h8888);
    chk("lu_add_hazard", {31'd0, hazard_stall}, 32'd0);

    // Hold for 3 cycles with a WB to the held rs landing in the second cycle.
    add = '{v:1, rs:9, rt:4, rd:5, rs_d:'h1, rt_d:'h44, op:3'b010, dst:1, ctl:5'b10000,
            default:'0};
    drive_id(add);
    tick();
    chk("st_loaded", alu_a, 32'h1);
    junk = '{v:1, rs:9, rt:9, rd:1, rs_d:'h7777, rt_d:'h7777, op:3'b110, dst:1,
             ctl:5'b10111, default:'0};
    drive_id(junk);
    stall = 1'b1;
    tick();
    chk("st_c1_alu_a", alu_a, 32'h1);
    chk("st_c1_dest", {27'd0, ex_dest}, 32'd5);
    wb_reg_write = 1'b1; wb_rd = 5'd9; wb_result = 32'hABCD;
    tick();
    wb_reg_write = 1'b0; wb_rd = '0; wb_result = '0;
    #1;
    chk("st_c2_held_update", alu_a, 32'hABCD);
    tick();
    stall = 1'b0;
    #1;
    chk("st_rel_alu_a", alu_a, 32'hABCD);
    chk("st_rel_store", ex_store_data, 32'h44);
    chk("st_rel_valid", {31'd0, ex_valid}, 32'd1);
    chk("st_rel_ctl", {27'd0, ex_ctl()}, {27'd0, 5'b10000});

    // Hold beats bubble, then flush together with hazard and a pending load.
    lw  = '{v:1, rs:2, rt:8, rd:0, rs_d:'h2000, imm:'h8, op:3'b010, src:1, ctl:5'b11010,
            default:'0};
    add = '{v:1, rs:3, rt:8, rd:10, rs_d:'h3, rt_d:'h0, op:3'b010, dst:1, ctl:5'b10000,
            default:'0};
    drive_id(lw);
    tick();
    drive_id(add);
    stall = 1'b1;
    #1;
    chk("fl_hazard_stall", {31'd0, hazard_stall}, 32'd1);
    tick();
    chk("fl_hold_valid", {31'd0, ex_valid}, 32'd1);
    chk("fl_hold_mem_read", {31'd0, ex_mem_read}, 32'd1);
    stall = 1'b0;
    flush = 1'b1;
    #1;
    chk("fl_hazard_pre", {31'd0, hazard_stall}, 32'd1);
    tick();
    flush = 1'b0;
    chk("fl_bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl_bubble_ctl", {27'd0, ex_ctl()}, 32'd0);
    chk("fl_bubble_aluctl", {29'd0, alu_control}, 32'd0);
    chk("fl_bubble_hazard", {31'd0, hazard_stall}, 32'd0);
    tick();
    chk("fl_next_valid", {31'd0, ex_valid}, 32'd1);
    chk("fl_next_dest", {27'd0, ex_dest}, 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
